// File: rtl/matmul_apb_slave.sv
// APB register front end for the matmul accelerator: operand/control
// registers, compute launch, and capture of result matrix and flags.
module matmul_apb_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_DIM    = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   psel_i,
    input  logic                                   penable_i,
    input  logic                                   pwrite_i,
    input  logic [ADDR_WIDTH-1:0]                  paddr_i,
    input  logic [BUS_WIDTH-1:0]                   pwdata_i,
    input  logic [BUS_WIDTH/8-1:0]                 pstrb_i,
    output logic [BUS_WIDTH-1:0]                   prdata_o,
    output logic                                   pready_o,
    output logic                                   pslverr_o,
    output logic                                   start_o,
    output logic [5:0]                             dims_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]           a_mat_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]           b_mat_o,
    input  logic                                   done_i,
    input  logic [BUS_WIDTH-1:0]                   flags_i,
    input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]   result_i,
    output logic                                   busy_o
);
    localparam int STRB_W = BUS_WIDTH/8;
    localparam int ROW_W  = MAX_DIM*DATA_WIDTH;
    localparam int NELEM  = MAX_DIM*MAX_DIM;
    localparam int ROW_AW = $clog2(MAX_DIM);

    typedef enum logic [1:0] {APB_IDLE, APB_RD_WAIT, APB_RESP} apb_state_e;
    typedef enum logic {CMP_IDLE, CMP_BUSY} cmp_state_e;

    apb_state_e           apb_q, apb_d;
    cmp_state_e           cmp_q, cmp_d;
    logic [5:0]           dims_q, dims_d;
    logic [ROW_W-1:0]     a_q [MAX_DIM];
    logic [ROW_W-1:0]     a_d [MAX_DIM];
    logic [ROW_W-1:0]     b_q [MAX_DIM];
    logic [ROW_W-1:0]     b_d [MAX_DIM];
    logic [BUS_WIDTH-1:0] sp_q [NELEM];
    logic [BUS_WIDTH-1:0] sp_d [NELEM];
    logic [BUS_WIDTH-1:0] flags_q, flags_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                 rerr_q, rerr_d;
    logic                 start_q, start_d;

    logic [2:0]           region;
    logic [3:0]           idx;
    logic [ROW_AW-1:0]    row;
    logic                 busy;
    logic                 wr_err;
    logic                 rd_err;
    logic [BUS_WIDTH-1:0] ctrl_cur;
    logic [BUS_WIDTH-1:0] ctrl_new;
    logic [BUS_WIDTH-1:0] rd_val;
    logic                 unused_paddr;

    assign region       = paddr_i[4:2];
    assign idx          = paddr_i[8:5];
    assign row          = idx[ROW_AW-1:0];
    assign busy         = (cmp_q == CMP_BUSY);
    assign unused_paddr = ^{paddr_i[ADDR_WIDTH-1:9], paddr_i[1:0]};
    assign ctrl_cur     = {{(BUS_WIDTH-8){1'b0}}, busy, dims_q, 1'b0};
    assign ctrl_new     = merge(ctrl_cur, pwdata_i, pstrb_i);
    assign rd_err       = (region > 3'd4);

    function automatic logic [BUS_WIDTH-1:0] merge(
        input logic [BUS_WIDTH-1:0] old_v,
        input logic [BUS_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]    strb
    );
        logic [BUS_WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        wr_err = 1'b1;
        rd_val = '0;
        case (region)
            3'd0: begin wr_err = busy; rd_val = ctrl_cur; end
            3'd1: begin wr_err = busy; rd_val = a_q[row]; end
            3'd2: begin wr_err = busy; rd_val = b_q[row]; end
            3'd3: rd_val = flags_q;
            3'd4: rd_val = sp_q[idx];
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        apb_d     = apb_q;
        cmp_d     = cmp_q;
        dims_d    = dims_q;
        a_d       = a_q;
        b_d       = b_q;
        sp_d      = sp_q;
        flags_d   = flags_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        start_d   = 1'b0;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        case (apb_q)
            APB_IDLE: begin
                if (psel_i && penable_i && pwrite_i) begin
                    pready_o  = 1'b1;
                    pslverr_o = wr_err;
                    if (!wr_err) begin
                        case (region)
                            3'd0: begin
                                dims_d  = ctrl_new[6:1];
                                start_d = ctrl_new[0];
                            end
                            3'd1: a_d[row] = merge(a_q[row], pwdata_i, pstrb_i);
                            3'd2: b_d[row] = merge(b_q[row], pwdata_i, pstrb_i);
                            default: ;
                        endcase
                    end
                end else if (psel_i && penable_i) begin
                    apb_d = APB_RD_WAIT;
                end
            end
            APB_RD_WAIT: begin
                rdata_d = rd_err ? '0 : rd_val;
                rerr_d  = rd_err;
                apb_d   = APB_RESP;
            end
            APB_RESP: begin
                pready_o  = 1'b1;
                pslverr_o = rerr_q;
                prdata_o  = rdata_q;
                apb_d     = APB_IDLE;
            end
            default: apb_d = APB_IDLE;
        endcase
        // a START write can only be accepted while idle, so it never races done_i
        if (busy && done_i) begin
            cmp_d   = CMP_IDLE;
            flags_d = flags_i;
            for (int e = 0; e < NELEM; e++) begin
                sp_d[e] = result_i[e*BUS_WIDTH +: BUS_WIDTH];
            end
        end else if (start_d) begin
            cmp_d = CMP_BUSY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            apb_q   <= APB_IDLE;
            cmp_q   <= CMP_IDLE;
            dims_q  <= '0;
            flags_q <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            start_q <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) begin
                a_q[r] <= '0;
                b_q[r] <= '0;
            end
            for (int e = 0; e < NELEM; e++) sp_q[e] <= '0;
        end else begin
            apb_q   <= apb_d;
            cmp_q   <= cmp_d;
            dims_q  <= dims_d;
            flags_q <= flags_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sp_q    <= sp_d;
        end
    end

    assign start_o = start_q;
    assign busy_o  = busy;
    assign dims_o  = dims_q;

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_rows
        assign a_mat_o[r*BUS_WIDTH +: BUS_WIDTH] = a_q[r];
        assign b_mat_o[r*BUS_WIDTH +: BUS_WIDTH] = b_q[r];
    end
endmodule
